// File: rtl/store_buffer_pkg.sv
// Shared types for the store buffer: access size, entry record and size decode.
package store_buffer_pkg;

    // Widest address/data the entry record can hold; the top's parameters must not exceed these.
    localparam int SB_ADDR_W = 32;
    localparam int SB_DATA_W = 64;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2,
        MEM_D = 2'd3
    } mem_size_t;

    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
        mem_size_t            size;
    } sb_entry_t;

    function automatic logic [3:0] mem_size_bytes(input mem_size_t size);
        case (size)
            MEM_B:   return 4'd1;
            MEM_H:   return 4'd2;
            MEM_W:   return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/sb_fwd_lookup.sv
// Youngest-first overlap scan of the occupied store-buffer slots for a load.
module sb_fwd_lookup
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH) + 1
) (
    input  sb_entry_t              entries [DEPTH],
    input  logic [PTR_W-1:0]       head,
    input  logic [PTR_W-1:0]       tail,
    input  logic [SB_ADDR_W-1:0]   ld_addr,
    input  mem_size_t              ld_size,
    output logic                   hit,
    output logic                   conflict,
    output logic [PTR_W-2:0]       hit_idx
);

    localparam int IDX_W = PTR_W - 1;

    logic [PTR_W-1:0]     count;
    logic [IDX_W-1:0]     idx;
    logic [SB_ADDR_W:0]   ld_lo, ld_hi, e_lo, e_hi;

    // Walk oldest to youngest so the last overlapping entry (the youngest) decides the result.
    // Ranges are computed one bit wider so an access at the top of memory does not wrap.
    always_comb begin
        hit      = 1'b0;
        conflict = 1'b0;
        hit_idx  = '0;
        idx      = '0;
        e_lo     = '0;
        e_hi     = '0;
        count    = tail - head;
        ld_lo    = {1'b0, ld_addr};
        ld_hi    = ld_lo + (SB_ADDR_W+1)'(mem_size_bytes(ld_size));
        for (int k = 0; k < DEPTH; k++) begin
            if (PTR_W'(k) < count) begin
                idx  = head[IDX_W-1:0] + IDX_W'(k);
                e_lo = {1'b0, entries[idx].addr};
                e_hi = e_lo + (SB_ADDR_W+1)'(mem_size_bytes(entries[idx].size));
                if ((e_lo < ld_hi) && (ld_lo < e_hi)) begin
                    if ((e_lo == ld_lo) && (entries[idx].size == ld_size)) begin
                        hit      = 1'b1;
                        conflict = 1'b0;
                        hit_idx  = idx;
                    end else begin
                        hit      = 1'b0;
                        conflict = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer: speculative stores are pushed at tail, committed by
// retire (cmt pointer), discarded on recover and drained from head to the dcache.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int COMMIT_WIDTH = 2,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    st_valid,
    input  logic [ADDR_W-1:0]       st_addr,
    input  logic [DATA_W-1:0]       st_data,
    input  mem_size_t               st_size,
    output logic                    st_ready,
    input  logic [COMMIT_WIDTH-1:0] store_retire,
    input  logic                    recover,
    input  logic [ADDR_W-1:0]       ld_addr,
    input  mem_size_t               ld_size,
    output logic                    fwd_hit,
    output logic [DATA_W-1:0]       fwd_data,
    output logic                    fwd_conflict,
    output logic                    mem_valid,
    input  logic                    mem_ready,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_data,
    output mem_size_t               mem_size,
    output logic                    empty
);

    localparam int PTR_W = $clog2(DEPTH) + 1;
    localparam int IDX_W = PTR_W - 1;

    logic [PTR_W-1:0] head_q, cmt_q, tail_q;
    logic [PTR_W-1:0] head_d, cmt_d, tail_d;
    logic [PTR_W-1:0] count, retire_cnt;
    logic             push, pop;
    sb_entry_t        entries_q [DEPTH];
    sb_entry_t        head_entry;
    logic [IDX_W-1:0] fwd_idx;

    assign count      = tail_q - head_q;
    assign st_ready   = (count != PTR_W'(DEPTH));
    assign empty      = (head_q == tail_q);
    assign mem_valid  = (head_q != cmt_q);
    assign head_entry = entries_q[head_q[IDX_W-1:0]];
    assign mem_addr   = head_entry.addr[ADDR_W-1:0];
    assign mem_data   = head_entry.data[DATA_W-1:0];
    assign mem_size   = head_entry.size;

    // A recover wins over a same-cycle push, so the dropped store never lands.
    assign push = st_valid && st_ready && !recover;
    assign pop  = mem_valid && mem_ready;

    // Count retiring stores this cycle.
    always_comb begin
        retire_cnt = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            retire_cnt = retire_cnt + PTR_W'(store_retire[i]);
        end
    end

    // Pointer update: retire first, then recover rewinds tail onto the new cmt, else push.
    always_comb begin
        head_d = head_q + PTR_W'(pop);
        cmt_d  = cmt_q + retire_cnt;
        tail_d = tail_q;
        if (recover) begin
            tail_d = cmt_d;
        end else if (push) begin
            tail_d = tail_q + PTR_W'(1);
        end
    end

    // Pointer registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q <= '0;
            cmt_q  <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            cmt_q  <= cmt_d;
            tail_q <= tail_d;
        end
    end

    // Entry storage, written at the tail slot on an accepted push.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else if (push) begin
            entries_q[tail_q[IDX_W-1:0]] <= '{addr: SB_ADDR_W'(st_addr),
                                              data: SB_DATA_W'(st_data),
                                              size: st_size};
        end
    end

    sb_fwd_lookup #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fwd_lookup (
        .entries  (entries_q),
        .head     (head_q),
        .tail     (tail_q),
        .ld_addr  (SB_ADDR_W'(ld_addr)),
        .ld_size  (ld_size),
        .hit      (fwd_hit),
        .conflict (fwd_conflict),
        .hit_idx  (fwd_idx)
    );

    assign fwd_data = fwd_hit ? entries_q[fwd_idx].data[DATA_W-1:0] : '0;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: a vector table plus hand sequences for
// full, recover, drain stall and asynchronous reset.
module tb_store_buffer;
    import store_buffer_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [63:0] st_data;
    mem_size_t   st_size;
    logic        st_ready;
    logic [1:0]  store_retire;
    logic        recover;
    logic [31:0] ld_addr;
    mem_size_t   ld_size;
    logic        fwd_hit;
    logic [63:0] fwd_data;
    logic        fwd_conflict;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [63:0] mem_data;
    mem_size_t   mem_size;
    logic        empty;

    int n_checks = 0;
    int n_pass   = 0;

    store_buffer #(.DEPTH(8), .COMMIT_WIDTH(2), .ADDR_W(32), .DATA_W(64)) dut (
        .clock(clock), .reset(reset),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
        .st_ready(st_ready), .store_retire(store_retire), .recover(recover),
        .ld_addr(ld_addr), .ld_size(ld_size),
        .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_conflict(fwd_conflict),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_size(mem_size), .empty(empty)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        st_valid;
        logic [31:0] st_addr;
        logic [63:0] st_data;
        mem_size_t   st_size;
        logic [1:0]  retire;
        logic        recover;
        logic        mem_ready;
        logic [31:0] ld_addr;
        mem_size_t   ld_size;
        logic        e_st_ready;
        logic        e_mem_valid;
        logic [31:0] e_mem_addr;
        logic [63:0] e_mem_data;
        logic        e_empty;
        logic        e_hit;
        logic [63:0] e_fwd_data;
        logic        e_conflict;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic idle();
        st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = MEM_B;
        store_retire = 2'b00; recover = 1'b0; mem_ready = 1'b0;
        ld_addr = '0; ld_size = MEM_B;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        idle();
        #2 reset = 1'b1;
        #2 reset = 1'b0;
    endtask

    task automatic push(input logic [31:0] a, input logic [63:0] d, input mem_size_t s);
        st_valid = 1'b1; st_addr = a; st_data = d; st_size = s;
        step();
        st_valid = 1'b0;
    endtask

    initial begin
        logic seen;

        // st_valid addr data size | retire recover mem_ready ld_addr ld_size |
        // exp: st_ready mem_valid mem_addr mem_data empty hit fwd_data conflict
        vecs[0]  = '{1'b1, 32'h100, 64'h11223344, MEM_W, 2'b00, 1'b0, 1'b0, 32'h100, MEM_W,
                     1'b1, 1'b0, 32'h0,   64'h0,        1'b0, 1'b1, 64'h11223344, 1'b0};
        vecs[1]  = '{1'b0, 32'h0,   64'h0,        MEM_B, 2'b01, 1'b0, 1'b1, 32'h102, MEM_H,
                     1'b1, 1'b1, 32'h100, 64'h11223344, 1'b0, 1'b0, 64'h0,        1'b1};
        vecs[2]  = '{1'b0, 32'h0,   64'h0,        MEM_B, 2'b00, 1'b0, 1'b1, 32'h104, MEM_W,
                     1'b1, 1'b0, 32'h0,   64'h0,        1'b1, 1'b0, 64'h0,        1'b0};
        vecs[3]  = '{1'b1, 32'h200, 64'hAA,       MEM_D, 2'b00, 1'b0, 1'b0, 32'h200, MEM_D,
                     1'b1, 1'b0, 32'h0,   64'h0,        1'b0, 1'b1, 64'hAA,       1'b0};
        vecs[4]  = '{1'b1, 32'h200, 64'hBB,       MEM_D, 2'b00, 1'b0, 1'b0, 32'h200, MEM_D,
                     1'b1, 1'b0, 32'h0,   64'h0,        1'b0, 1'b1, 64'hBB,       1'b0};
        vecs[5]  = '{1'b0, 32'h0,   64'h0,        MEM_B, 2'b00, 1'b0, 1'b0, 32'h204, MEM_W,
                     1'b1, 1'b0, 32'h0,   64'h0,        1'b0, 1'b0, 64'h0,        1'b1};
        vecs[6]  = '{1'b0, 32'h0,   64'h0,        MEM_B, 2'b00, 1'b0, 1'b0, 32'h208, MEM_B,
                     1'b1, 1'b0, 32'h0,   64'h0,        1'b0, 1'b0, 64'h0,        1'b0};
        vecs[7]  = '{1'b0, 32'h0,   64'h0,        MEM_B, 2'b00, 1'b0, 1'b0, 32'h1FC, MEM_D,
                     1'b1, 1'b0, 32'h0,   64'h0,        1'b0, 1'b0, 64'h0,        1'b1};
        vecs[8]  = '{1'b0, 32'h0,   64'h0,        MEM_B, 2'b11, 1'b0, 1'b0, 32'h200, MEM_D,
                     1'b1, 1'b1, 32'h200, 64'hAA,       1'b0, 1'b1, 64'hBB,       1'b0};
        vecs[9]  = '{1'b0, 32'h0,   64'h0,        MEM_B, 2'b00, 1'b0, 1'b1, 32'h200, MEM_D,
                     1'b1, 1'b1, 32'h200, 64'hBB,       1'b0, 1'b1, 64'hBB,       1'b0};
        vecs[10] = '{1'b0, 32'h0,   64'h0,        MEM_B, 2'b00, 1'b0, 1'b1, 32'h200, MEM_D,
                     1'b1, 1'b0, 32'h0,   64'h0,        1'b1, 1'b0, 64'h0,        1'b0};

        idle();
        reset = 1'b1;
        #12 reset = 1'b0;

        chk("rst_st_ready", 64'(st_ready), 64'd1);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_mem_valid", 64'(mem_valid), 64'd0);
        chk("rst_fwd_hit", 64'(fwd_hit), 64'd0);
        chk("rst_fwd_conflict", 64'(fwd_conflict), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_data", mem_data, 64'd0);
        chk("rst_fwd_data", fwd_data, 64'd0);

        for (int i = 0; i < 11; i++) begin
            st_valid = vecs[i].st_valid; st_addr = vecs[i].st_addr;
            st_data = vecs[i].st_data; st_size = vecs[i].st_size;
            store_retire = vecs[i].retire; recover = vecs[i].recover;
            mem_ready = vecs[i].mem_ready;
            ld_addr = vecs[i].ld_addr; ld_size = vecs[i].ld_size;
            step();
            chk($sformatf("v%0d_st_ready", i), 64'(st_ready), 64'(vecs[i].e_st_ready));
            chk($sformatf("v%0d_mem_valid", i), 64'(mem_valid), 64'(vecs[i].e_mem_valid));
            if (vecs[i].e_mem_valid) begin
                chk($sformatf("v%0d_mem_addr", i), 64'(mem_addr), 64'(vecs[i].e_mem_addr));
                chk($sformatf("v%0d_mem_data", i), mem_data, vecs[i].e_mem_data);
            end
            chk($sformatf("v%0d_empty", i), 64'(empty), 64'(vecs[i].e_empty));
            chk($sformatf("v%0d_fwd_hit", i), 64'(fwd_hit), 64'(vecs[i].e_hit));
            chk($sformatf("v%0d_fwd_data", i), fwd_data, vecs[i].e_fwd_data);
            chk($sformatf("v%0d_fwd_conflict", i), 64'(fwd_conflict), 64'(vecs[i].e_conflict));
        end
        idle();

        // Fill to full (pointers start mid-ring, so this also wraps).
        for (int i = 0; i < 8; i++) begin
            push(32'h1000 + 32'(8 * i), 64'(i), MEM_D);
            chk($sformatf("full_st_ready_%0d", i), 64'(st_ready), (i < 7) ? 64'd1 : 64'd0);
        end
        st_valid = 1'b1; st_addr = 32'h2000; st_data = 64'h99; st_size = MEM_D;
        step();
        chk("full_ignored_ready", 64'(st_ready), 64'd0);
        ld_addr = 32'h2000; ld_size = MEM_D;
        #1;
        chk("full_ignored_lookup", 64'(fwd_hit), 64'd0);
        ld_addr = 32'h1038;
        #1;
        chk("full_last_hit", 64'(fwd_hit), 64'd1);
        chk("full_last_data", fwd_data, 64'd7);
        st_addr = 32'h3000;
        store_retire = 2'b11;
        step();
        store_retire = 2'b00;
        chk("full_after_retire_ready", 64'(st_ready), 64'd0);
        chk("full_after_retire_valid", 64'(mem_valid), 64'd1);
        chk("full_after_retire_addr", 64'(mem_addr), 64'h1000);
        mem_ready = 1'b1;
        #1;
        chk("full_pop_same_cycle_ready", 64'(st_ready), 64'd0);
        step();
        st_valid = 1'b0; mem_ready = 1'b0;
        chk("full_pop_next_ready", 64'(st_ready), 64'd1);
        chk("full_pop_next_addr", 64'(mem_addr), 64'h1008);
        ld_addr = 32'h3000;
        #1;
        chk("full_held_not_taken", 64'(fwd_hit), 64'd0);
        do_reset();

        // Recover with a same-cycle retire and a same-cycle push.
        push(32'h10, 64'hA, MEM_W);
        push(32'h20, 64'hB, MEM_W);
        push(32'h30, 64'hC, MEM_W);
        st_valid = 1'b1; st_addr = 32'h40; st_data = 64'hD; st_size = MEM_W;
        store_retire = 2'b01; recover = 1'b1;
        ld_addr = 32'h20; ld_size = MEM_W;
        #1;
        chk("rec_dropped_visible", 64'(fwd_hit), 64'd1);
        chk("rec_dropped_data", fwd_data, 64'hB);
        step();
        st_valid = 1'b0; store_retire = 2'b00; recover = 1'b0;
        chk("rec_mem_valid", 64'(mem_valid), 64'd1);
        chk("rec_mem_addr", 64'(mem_addr), 64'h10);
        chk("rec_mem_data", mem_data, 64'hA);
        chk("rec_mem_size", 64'(mem_size), 64'(MEM_W));
        chk("rec_b_gone", 64'(fwd_hit), 64'd0);
        mem_ready = 1'b1;
        step();
        chk("rec_empty", 64'(empty), 64'd1);
        seen = mem_valid;
        for (int i = 0; i < 3; i++) begin
            step();
            seen = seen | mem_valid;
        end
        mem_ready = 1'b0;
        chk("rec_no_more_drain", 64'(seen), 64'd0);
        ld_addr = 32'h40;
        #1;
        chk("rec_push_dropped", 64'(fwd_hit), 64'd0);
        do_reset();

        // Drain back-pressure: fields stable while stalled, order preserved.
        for (int i = 0; i < 4; i++) push(32'h400 + 32'(8 * i), 64'h100 + 64'(i), MEM_D);
        store_retire = 2'b11;
        step();
        step();
        store_retire = 2'b00;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("stall_addr_%0d", i), 64'(mem_addr), 64'h400);
            chk($sformatf("stall_data_%0d", i), mem_data, 64'h100);
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("order_valid_%0d", i), 64'(mem_valid), 64'd1);
            chk($sformatf("order_addr_%0d", i), 64'(mem_addr), 64'h400 + 64'(8 * i));
            mem_ready = 1'b1;
            step();
        end
        mem_ready = 1'b0;
        chk("order_empty", 64'(empty), 64'd1);
        do_reset();

        // Asynchronous reset while a committed store is on the dcache port.
        push(32'h500, 64'h55, MEM_W);
        store_retire = 2'b01;
        step();
        store_retire = 2'b00;
        chk("arst_pre_valid", 64'(mem_valid), 64'd1);
        mem_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("arst_mem_valid", 64'(mem_valid), 64'd0);
        chk("arst_empty", 64'(empty), 64'd1);
        chk("arst_mem_addr", 64'(mem_addr), 64'd0);
        #2 reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Parametrised store buffer between core and dcache; replaces the external store-buffer model in simulation.
- Holds speculative stores in program order. Marks them committed on retire signals from the commit stage and discards uncommitted ones on recover.
- Drains committed stores to the dcache one per cycle over a valid/ready port.
- Forwards store data to loads by address lookup.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 2.
- COMMIT_WIDTH, 2, width of the retire vector (stores retired per cycle).
- ADDR_W, 32, address width.
- DATA_W, 64, store data width.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- st_valid  in  1  store issued by the LSU this cycle
- st_addr  in  ADDR_W  store byte address
- st_data  in  DATA_W  store data, right-aligned
- st_size  in  mem_size_t  store size
- st_ready  out  1  buffer can accept a store (not full)
- store_retire  in  COMMIT_WIDTH  one bit per retiring store; popcount = stores committed this cycle
- recover  in  1  mispredict flush; drop all uncommitted entries
- ld_addr  in  ADDR_W  load lookup address
- ld_size  in  mem_size_t  load lookup size
- fwd_hit  out  1  youngest overlapping entry matches the load exactly
- fwd_data  out  DATA_W  data of the hit entry
- fwd_conflict  out  1  partial overlap; core must replay the load
- mem_valid  out  1  committed head entry is presented to the dcache
- mem_ready  in  1  dcache accepts the write
- mem_addr  out  ADDR_W  head address
- mem_data  out  DATA_W  head data
- mem_size  out  mem_size_t  head size
- empty  out  1  no valid entries

Behaviour:
- Circular queue with three pointers, each $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit:
  - head: oldest entry.
  - cmt: first uncommitted entry.
  - tail: next free slot.
- Invariant: head <= cmt <= tail in modulo order. count = tail-head.
- Reset values:
  - All pointers 0; all entry valid bits 0.
  - mem_valid=0, fwd_hit=0, fwd_conflict=0, st_ready=1, empty=1.
  - mem_addr, mem_data, mem_size and fwd_data = 0.
- Push:
  - When st_valid && st_ready, write the entry at tail and advance tail next cycle.
  - st_ready = (count != DEPTH), from registered state only.
  - st_valid while full is ignored; the LSU must hold the store.
- Retire:
  - cmt advances by popcount(store_retire).
  - Driving popcount greater than (tail-cmt) is illegal; the verification bench asserts it never happens.
  - A store pushed in cycle N can be retired at the earliest in cycle N+1.
- Recover:
  - Next cycle, tail := cmt after applying the same-cycle retire.
  - Priority within one cycle: retire, then recover, then push. A push in a recover cycle is dropped.
  - Committed entries and the drain in progress are unaffected.
- Drain:
  - mem_valid = (head != cmt), combinational from registers.
  - mem_addr, mem_data and mem_size show the head entry.
  - On mem_valid && mem_ready, head advances next cycle.
  - mem_valid holds until accepted; the fields are stable while mem_valid=1 and mem_ready=0.
- Forwarding (combinational, same cycle):
  - Byte range of an entry or load = [addr, addr + bytes(size)).
  - Scan all valid entries from tail-1 down to head.
  - The youngest entry whose range overlaps the load decides the result:
    - Equal addr and equal size: fwd_hit=1, fwd_data = that entry's data.
    - Any other overlap: fwd_conflict=1.
  - No overlap: both outputs 0.
  - The head entry being drained this cycle still participates.
  - Entries dropped by a recover in this cycle still participate until the next edge.
- Simultaneous push and pop while full: pop frees a slot only next cycle, so st_ready stays 0.
- Wrap-around: indices use the low bits of the pointers. full = (low bits equal && wrap bits differ).
- Reset mid-operation: all entries are lost, including committed ones. This is accepted for simulation.
- empty = (head == tail).

Decomposition:
- Shared package (alongside micro_op.svh): mem_size_t, sb_entry_t {addr, data, size}, and a function mem_size_bytes(mem_size_t) returning 1, 2, 4 or 8.
- One sub-module, sb_fwd_lookup: combinational youngest-first overlap scan. It takes the entry array, head, tail, ld_addr and ld_size, and returns hit, conflict and a hit index.

Test Plan:
- Push SW 0x100 data 0x11223344, retire bit next cycle, mem_ready=1 -> mem_valid=1 the cycle after retire with mem_addr=0x100, then empty=1 the following cycle.
- Push 8 stores without retiring (DEPTH=8) -> st_ready=0 after the 8th; a 9th st_valid is ignored; retire 2 and accept 1 -> st_ready=1 next cycle.
- Push A, B, C; retire A in the same cycle as recover -> tail=cmt=1; only A drains; B and C are never seen on mem_*.
- Push SD 0x200 = 0xAA, then SD 0x200 = 0xBB; load LD 0x200 -> fwd_hit=1, fwd_data=0xBB (youngest wins). Load LW 0x204 -> fwd_conflict=1.
- Retire 2 per cycle with store_retire=2'b11, holding mem_ready=0 for 5 cycles -> mem_* fields stable, head unchanged, order preserved after release.
- Assert reset asynchronously mid-drain with mem_valid=1 -> mem_valid=0 and empty=1 immediately, without waiting for a clock edge.
